// File: rtl/ct_ciu_age_arb.sv
// ct_ciu_age_arb: oldest-first arbiter for CIU request buffers with an internal age matrix and a grant lock.
// Ports: ciu_icg_clk/cpurst_b clock and async active-low reset; alloc_vld/alloc_idx allocate one entry;
// dealloc_vld per-entry release mask; req_vld per-entry request; gnt_rdy downstream accept;
// sel_vld/sel/sel_idx presented grant; entry_vld/full/empty occupancy; alloc_err illegal-allocation pulse.
module ct_ciu_age_arb #(
  parameter int DEPTH = 24,
  parameter int IDX_W = 5
) (
  input  logic             ciu_icg_clk,
  input  logic             cpurst_b,
  input  logic             alloc_vld,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] dealloc_vld,
  input  logic [DEPTH-1:0] req_vld,
  input  logic             gnt_rdy,
  output logic             sel_vld,
  output logic [DEPTH-1:0] sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic [DEPTH-1:0] entry_vld,
  output logic             full,
  output logic             empty,
  output logic             alloc_err
);
  logic [DEPTH-1:0] age   [DEPTH];
  logic [DEPTH-1:0] age_n [DEPTH];
  logic [DEPTH-1:0] alloc_oh, alloc_win, surv, entry_vld_n, cand, osel, lock_oh;
  logic             alloc_ok, lock_vld, lock_hit;
  logic [IDX_W-1:0] lock_idx;
  always_comb begin
    alloc_oh = '0;
    lock_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_oh[i] = alloc_vld && alloc_idx == IDX_W'(i);
      lock_oh[i] = lock_vld && lock_idx == IDX_W'(i);
    end
    // an entry may be reused in the same cycle it is released
    alloc_win = alloc_oh & (~entry_vld | dealloc_vld);
    alloc_ok = |alloc_win;
    surv = entry_vld & ~dealloc_vld & ~alloc_win;
    entry_vld_n = (entry_vld & ~dealloc_vld) | alloc_win;
    cand = req_vld & entry_vld;
    osel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      osel[i] = cand[i] && !(|(cand & age[i]));
      // new entry sees all survivors as older; released and new columns are cleared everywhere
      age_n[i] = alloc_win[i] ? surv : age[i] & ~dealloc_vld & ~alloc_win & {DEPTH{~dealloc_vld[i]}};
    end
    lock_hit = |(lock_oh & cand);
    sel = lock_hit ? lock_oh : osel;
    sel_vld = |sel;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      sel_idx = sel_idx | (sel[i] ? IDX_W'(i) : '0);
  end
  always_ff @(posedge ciu_icg_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      entry_vld <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      alloc_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        age[i] <= '0;
    end else begin
      entry_vld <= entry_vld_n;
      for (int i = 0; i < DEPTH; i++)
        age[i] <= age_n[i];
      // hold an unaccepted grant, but drop it if that entry is released
      lock_vld <= sel_vld && !gnt_rdy && !(|(sel & dealloc_vld));
      lock_idx <= sel_idx;
      alloc_err <= alloc_vld && !alloc_ok;
    end
  end
  assign full = &entry_vld;
  assign empty = ~|entry_vld;
endmodule
